// File: rtl/echo_pkg.sv
// Shared types and helpers for the multichannel echo path: FSM states,
// channel index width and the output saturation function.
package echo_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_READ  = 3'd2,
        ST_CALC  = 3'd3,
        ST_OUT   = 3'd4
    } echo_state_e;

    function automatic int ch_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

    // Clamp a wide signed value into a w-bit two's complement range.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/echo_delay_ram.sv
// Single-port synchronous delay RAM: read-before-write, one cycle read latency,
// contents are not reset.
module echo_delay_ram #(
    parameter int WIDTH  = 16,
    parameter int WORDS  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [WORDS];
    logic [WIDTH-1:0] rdata_q;

    // Storage write and registered read of the old word at the same address.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/multichannel_echo.sv
// N-channel interleaved echo: one tagged sample per handshake, per-channel
// circular delay buffer, wet mix and feedback with saturation.
module multichannel_echo
    import echo_pkg::*;
#(
    parameter int audio_width      = 16,
    parameter int channels         = 2,
    parameter int delay_addr_width = 10,
    parameter int gain_width       = 8,
    localparam int CW              = ch_width(channels)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_valid,
    output logic                        i_ready,
    input  logic [CW-1:0]               i_channel,
    input  logic [audio_width-1:0]      i_audio,
    input  logic [delay_addr_width-1:0] i_delay,
    input  logic [gain_width-1:0]       i_mix,
    input  logic [gain_width-1:0]       i_feedback,
    input  logic                        i_enable,
    output logic                        o_valid,
    input  logic                        o_ready,
    output logic [CW-1:0]               o_channel,
    output logic [audio_width-1:0]      o_audio
);

    localparam int DEPTH = 1 << delay_addr_width;
    localparam int WORDS = channels * DEPTH;
    localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int PW    = audio_width + gain_width + 1;
    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);
    localparam logic [AW-1:0] LAST_A  = AW'(WORDS - 1);
    localparam logic [CW-1:0] LAST_CH = CW'(channels - 1);

    echo_state_e state_q, state_d;
    logic                        ready_q;
    logic [AW-1:0]               clr_q;
    logic [delay_addr_width-1:0] ptr_q;
    logic [CW-1:0]               ch_q;
    logic [audio_width-1:0]      x_q;
    logic [delay_addr_width-1:0] delay_q;
    logic [gain_width-1:0]       mix_q;
    logic [gain_width-1:0]       fb_q;
    logic                        en_q;
    logic                        o_valid_q;
    logic [CW-1:0]               o_ch_q;
    logic [audio_width-1:0]      o_audio_q;

    logic                        accept_s;
    logic                        ch_ok_s;
    logic [AW-1:0]               base_s;
    logic [delay_addr_width-1:0] rd_off_s;
    logic                        ram_we_s;
    logic [AW-1:0]               ram_addr_s;
    logic [audio_width-1:0]      ram_wdata_s;
    logic [audio_width-1:0]      ram_rdata_s;
    logic signed [PW-1:0]        d_ext_s, x_ext_s, mix_ext_s, fb_ext_s, wet_s, fbv_s;
    logic [audio_width-1:0]      y_s, w_s;

    assign accept_s = i_valid && ready_q;
    assign ch_ok_s  = int'(ch_q) < channels;
    assign base_s   = AW'(ch_q) * DEPTH_A;
    assign rd_off_s = ptr_q - delay_q;

    echo_delay_ram #(
        .WIDTH  (audio_width),
        .WORDS  (WORDS),
        .ADDR_W (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we_s),
        .addr_i  (ram_addr_s),
        .wdata_i (ram_wdata_s),
        .rdata_o (ram_rdata_s)
    );

    // State register; i_ready is registered from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_CLEAR;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == ST_IDLE);
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: state_d = (clr_q == LAST_A) ? ST_IDLE : ST_CLEAR;
            ST_IDLE:  state_d = accept_s ? ST_READ : ST_IDLE;
            ST_READ:  state_d = ST_CALC;
            ST_CALC:  state_d = ST_OUT;
            ST_OUT:   state_d = o_ready ? ST_IDLE : ST_OUT;
            default:  state_d = ST_CLEAR;
        endcase
    end

    // RAM port control: clearing, delayed read, then write-back of w.
    always_comb begin
        ram_we_s    = 1'b0;
        ram_addr_s  = '0;
        ram_wdata_s = '0;
        case (state_q)
            ST_CLEAR: begin
                ram_we_s   = 1'b1;
                ram_addr_s = clr_q;
            end
            ST_READ: begin
                ram_addr_s = base_s + AW'(rd_off_s);
            end
            ST_CALC: begin
                ram_we_s    = ch_ok_s;
                ram_addr_s  = base_s + AW'(ptr_q);
                ram_wdata_s = w_s;
            end
            default: begin
                ram_we_s = 1'b0;
            end
        endcase
    end

    // Wet and feedback arithmetic on the delayed sample.
    always_comb begin
        d_ext_s   = {{(PW - audio_width){ram_rdata_s[audio_width-1]}}, ram_rdata_s};
        x_ext_s   = {{(PW - audio_width){x_q[audio_width-1]}}, x_q};
        mix_ext_s = {{(PW - gain_width){1'b0}}, mix_q};
        fb_ext_s  = {{(PW - gain_width){1'b0}}, fb_q};
        wet_s     = (d_ext_s * mix_ext_s) >>> gain_width;
        fbv_s     = (d_ext_s * fb_ext_s) >>> gain_width;
        if (en_q) begin
            w_s = audio_width'(saturate(64'(x_ext_s + fbv_s), audio_width));
            y_s = ch_ok_s ? audio_width'(saturate(64'(x_ext_s + wet_s), audio_width)) : x_q;
        end else begin
            w_s = x_q;
            y_s = x_q;
        end
    end

    // Sample capture, clear address, frame pointer and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clr_q     <= '0;
            ptr_q     <= '0;
            ch_q      <= '0;
            x_q       <= '0;
            delay_q   <= '0;
            mix_q     <= '0;
            fb_q      <= '0;
            en_q      <= 1'b0;
            o_valid_q <= 1'b0;
            o_ch_q    <= '0;
            o_audio_q <= '0;
        end else begin
            if (state_q == ST_CLEAR) begin
                clr_q <= (clr_q == LAST_A) ? '0 : clr_q + AW'(1);
            end
            if (accept_s) begin
                ch_q    <= i_channel;
                x_q     <= i_audio;
                delay_q <= i_delay;
                mix_q   <= i_mix;
                fb_q    <= i_feedback;
                en_q    <= i_enable;
            end
            if (state_q == ST_CALC) begin
                o_valid_q <= 1'b1;
                o_audio_q <= y_s;
                o_ch_q    <= ch_q;
            end
            if ((state_q == ST_OUT) && o_ready) begin
                o_valid_q <= 1'b0;
                if (ch_q == LAST_CH) begin
                    ptr_q <= ptr_q + delay_addr_width'(1);
                end
            end
        end
    end

    assign i_ready   = ready_q;
    assign o_valid   = o_valid_q;
    assign o_channel = o_ch_q;
    assign o_audio   = o_audio_q;

endmodule

// File: tb/tb_multichannel_echo.sv
// Randomized self-checking bench for multichannel_echo against a frame-level
// behavioural model of the echo arithmetic.
module tb_multichannel_echo;

    localparam int NCH = 2;
    localparam int DEP = 16;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        i_ready;
    logic [0:0]  i_channel;
    logic [15:0] i_audio;
    logic [3:0]  i_delay;
    logic [7:0]  i_mix;
    logic [7:0]  i_feedback;
    logic        i_enable;
    logic        o_valid;
    logic        o_ready;
    logic [0:0]  o_channel;
    logic [15:0] o_audio;

    int n_cmp = 0;
    int n_err = 0;
    int mbuf [NCH][DEP];
    int mptr;

    multichannel_echo #(
        .audio_width      (16),
        .channels         (NCH),
        .delay_addr_width (4),
        .gain_width       (8)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .i_valid    (i_valid),
        .i_ready    (i_ready),
        .i_channel  (i_channel),
        .i_audio    (i_audio),
        .i_delay    (i_delay),
        .i_mix      (i_mix),
        .i_feedback (i_feedback),
        .i_enable   (i_enable),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o_channel  (o_channel),
        .o_audio    (o_audio)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // floor(d*g / 256)
    function automatic int scale(input int d, input int g);
        int p;
        p = d * g;
        if (p >= 0) return p / 256;
        return -((-p + 255) / 256);
    endfunction

    task automatic model_clear();
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < DEP; k++)
                mbuf[c][k] = 0;
        mptr = 0;
    endtask

    task automatic model_step(input int ch, input int x, input int dly, input int mix,
                              input int fb, input int en, output int y);
        int d, w;
        d = mbuf[ch][(mptr - dly + DEP) % DEP];
        if (en != 0) begin
            y = sat16(x + scale(d, mix));
            w = sat16(x + scale(d, fb));
        end else begin
            y = x;
            w = x;
        end
        mbuf[ch][mptr] = w;
        if (ch == NCH - 1) mptr = (mptr + 1) % DEP;
    endtask

    task automatic do_reset();
        int n, vbad;
        rst_n   = 1'b0;
        i_valid = 1'b0;
        o_ready = 1'b1;
        #1;
        check_eq("rst_i_ready", int'(i_ready), 0);
        check_eq("rst_o_valid", int'(o_valid), 0);
        check_eq("rst_o_channel", int'(o_channel), 0);
        check_eq("rst_o_audio", int'(o_audio), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
        n = 0;
        vbad = 0;
        while (!i_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (o_valid) vbad = 1;
        end
        check_eq("clear_cycles", n, 32);
        check_eq("valid_in_clear", vbad, 0);
    endtask

    task automatic drive_accept(input int ch, input int x, input int dly, input int mix,
                                input int fb, input int en);
        int n;
        n = 0;
        while (!i_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("ready_wait", int'(i_ready), 1);
        i_valid    = 1'b1;
        i_channel  = 1'(ch);
        i_audio    = 16'(x);
        i_delay    = 4'(dly);
        i_mix      = 8'(mix);
        i_feedback = 8'(fb);
        i_enable   = 1'(en);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int lat;
        lat = 0;
        while (!o_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("latency", lat, 2);
    endtask

    task automatic xfer(input int ch, input int x, input int dly, input int mix,
                        input int fb, input int en, input int stall, output int y_obs);
        int y_exp, bad;
        logic [15:0] held_a;
        logic [0:0]  held_c;
        drive_accept(ch, x, dly, mix, fb, en);
        model_step(ch, x, dly, mix, fb, en, y_exp);
        wait_valid();
        y_obs = int'($signed(o_audio));
        check_eq("out_channel", int'(o_channel), ch);
        check_eq("out_audio", y_obs, y_exp);
        if (stall > 0) begin
            o_ready = 1'b0;
            held_a  = o_audio;
            held_c  = o_channel;
            bad     = 0;
            for (int k = 0; k < stall; k++) begin
                @(posedge clk);
                #1;
                if (o_audio !== held_a || o_channel !== held_c || i_ready || !o_valid) bad = 1;
            end
            check_eq("stall_stable", bad, 0);
            o_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check_eq("valid_drop", int'(o_valid), 0);
    endtask

    task automatic impulse_run(input int frames, input int fb);
        int y;
        for (int f = 0; f < frames; f++) begin
            for (int c = 0; c < NCH; c++) begin
                xfer(c, (f == 0 && c == 0) ? 16384 : 0, 4, 128, fb, 1, 0, y);
                if (c == 0 && f == 0) check_eq("imp_f0", y, 16384);
                if (c == 0 && f == 4) check_eq("imp_f4", y, 8192);
                if (c == 0 && f == 8) check_eq("imp_f8", y, (fb != 0) ? 4096 : 0);
                if (c == 0 && f == 12) check_eq("imp_f12", y, (fb != 0) ? 2048 : 0);
                if (c == 1) check_eq("imp_ch1", y, 0);
            end
        end
    endtask

    task automatic sat_run(input int x, input int lim);
        int y;
        for (int f = 0; f < 4; f++) begin
            for (int c = 0; c < NCH; c++) begin
                xfer(c, x, 1, 255, 0, 1, 0, y);
                if (f >= 1) check_eq("sat_clamp", y, lim);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int y;
        rst_n      = 1'b0;
        i_valid    = 1'b0;
        i_channel  = 1'b0;
        i_audio    = 16'h0000;
        i_delay    = 4'h0;
        i_mix      = 8'h00;
        i_feedback = 8'h00;
        i_enable   = 1'b0;
        o_ready    = 1'b1;

        do_reset();
        impulse_run(16, 0);

        do_reset();
        impulse_run(16, 128);

        do_reset();
        sat_run(28672, 32767);
        do_reset();
        sat_run(-28672, -32768);

        for (int i = 0; i < 64; i++) begin
            xfer($urandom_range(0, 1), int'($urandom_range(0, 65535)) - 32768,
                 $urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255),
                 ($urandom_range(0, 3) != 0) ? 1 : 0,
                 (i % 8 == 3) ? 10 : $urandom_range(0, 2), y);
        end

        // Abort a sample while it sits in the output register.
        drive_accept(0, 12345, 3, 200, 100, 1);
        o_ready = 1'b0;
        wait_valid();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_async_valid", int'(o_valid), 0);
        do_reset();
        impulse_run(8, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
